// File: rtl/count_event_unit_if.sv
// Bus bundle between the counter-side producer/consumer and count_event_unit.
// master drives counter/config/ack inputs; slave is the event unit itself.
interface count_event_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] count_in;
  logic             m_in;
  logic             cfg_wr;
  logic [1:0]       cfg_sel;
  logic [WIDTH-1:0] cfg_data;
  logic             cap_trig;
  logic             cap_rd;
  logic [WIDTH-1:0] cap_value;
  logic             cap_valid;
  logic             cap_ovr;
  logic [3:0]       status;
  logic [3:0]       irq_ack;
  logic             irq;

  modport master (
    output count_in, m_in, cfg_wr, cfg_sel, cfg_data, cap_trig, cap_rd, irq_ack,
    input  cap_value, cap_valid, cap_ovr, status, irq
  );

  modport slave (
    input  count_in, m_in, cfg_wr, cfg_sel, cfg_data, cap_trig, cap_rd, irq_ack,
    output cap_value, cap_valid, cap_ovr, status, irq
  );
endinterface

// File: rtl/count_event_unit.sv
// Sticky event monitor for an up/down counter: compare matches, wrap, optional capture.
// Define COUNT_EVENT_CAPTURE_EN to build the synchronised external capture path.
module count_event_unit #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  count_event_unit_if.slave bus
);

  logic [WIDTH-1:0] cmp0_q, cmp1_q, prev_count_q;
  logic [3:0]       mask_q, status_q, status_d, ev;
  logic             prev_eq0_q, prev_eq1_q, irq_q;
  logic             eq0, eq1, wrap_ev, cap_ev;

  assign eq0 = (bus.count_in == cmp0_q);
  assign eq1 = (bus.count_in == cmp1_q);

  // A reload from all-ones to zero while counting up looks exactly like a wrap.
  assign wrap_ev = ( bus.m_in && (prev_count_q == '1) && (bus.count_in == '0)) ||
                   (!bus.m_in && (prev_count_q == '0) && (bus.count_in == '1));

  always_comb begin
    ev       = {wrap_ev, cap_ev, eq1 & ~prev_eq1_q, eq0 & ~prev_eq0_q};
    status_d = (status_q & ~bus.irq_ack) | ev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp0_q       <= '1;
      cmp1_q       <= '1;
      mask_q       <= '0;
      prev_count_q <= '0;
      prev_eq0_q   <= 1'b0;
      prev_eq1_q   <= 1'b0;
      status_q     <= '0;
      irq_q        <= 1'b0;
    end else begin
      prev_count_q <= bus.count_in;
      prev_eq0_q   <= eq0;
      prev_eq1_q   <= eq1;
      status_q     <= status_d;
      // irq follows the next status but the current mask, so mask writes land one cycle later.
      irq_q        <= |(status_d & mask_q);
      if (bus.cfg_wr) begin
        unique case (bus.cfg_sel)
          2'd0:    cmp0_q <= bus.cfg_data;
          2'd1:    cmp1_q <= bus.cfg_data;
          2'd2:    mask_q <= bus.cfg_data[3:0];
          default: ;
        endcase
      end
    end
  end

  assign bus.status = status_q;
  assign bus.irq    = irq_q;

`ifdef COUNT_EVENT_CAPTURE_EN
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_last_q;
  logic [WIDTH-1:0]       cap_value_q;
  logic                   cap_valid_q, cap_ovr_q;

  assign cap_ev = sync_q[SYNC_STAGES-1] & ~sync_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      sync_last_q <= 1'b0;
      cap_value_q <= '0;
      cap_valid_q <= 1'b0;
      cap_ovr_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.cap_trig};
      sync_last_q <= sync_q[SYNC_STAGES-1];
      if (cap_ev) begin
        cap_value_q <= bus.count_in;
        cap_valid_q <= 1'b1;
        // A read in the same cycle consumed the old value, so nothing was lost.
        if (cap_valid_q && !bus.cap_rd) cap_ovr_q <= 1'b1;
      end else if (bus.cap_rd) begin
        cap_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cap_value = cap_value_q;
  assign bus.cap_valid = cap_valid_q;
  assign bus.cap_ovr   = cap_ovr_q;
`else
  localparam int sync_stages_unused = SYNC_STAGES;
  logic cap_inputs_unused;

  assign cap_inputs_unused = bus.cap_trig ^ bus.cap_rd;
  assign cap_ev            = 1'b0;
  assign bus.cap_value     = '0;
  assign bus.cap_valid     = 1'b0;
  assign bus.cap_ovr       = 1'b0;
`endif

endmodule

// File: tb/tb_count_event_unit.sv
// Self-checking bench for count_event_unit: directed scenarios plus randomised traffic
// checked against an event-rule reference model.
module tb_count_event_unit;
  localparam int W    = 32;
  localparam int SYNC = 2;
  localparam logic [W-1:0] ONES = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  count_event_unit_if #(.WIDTH(W)) bus ();

  count_event_unit #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int fails  = 0;

  // Reference state
  logic [W-1:0] m_cmp [2];
  logic [3:0]   m_mask, m_status;
  logic         m_irq;
  logic [W-1:0] m_prev_count;
  bit           m_prev_eq [2];
  logic [W-1:0] m_cap_value;
  logic         m_cap_valid, m_cap_ovr;
  bit           trig_hist [$];

  task automatic model_reset();
    m_cmp[0] = ONES; m_cmp[1] = ONES;
    m_mask = '0; m_status = '0; m_irq = 1'b0;
    m_prev_count = '0; m_prev_eq[0] = 0; m_prev_eq[1] = 0;
    m_cap_value = '0; m_cap_valid = 1'b0; m_cap_ovr = 1'b0;
    trig_hist.delete();
    for (int i = 0; i < SYNC + 2; i++) trig_hist.push_back(1'b0);
  endtask

  // Applies the event rules for one rising edge using the inputs held before it.
  task automatic model_edge();
    logic [3:0] ev;
    bit eq;
    ev = '0;
    for (int i = 0; i < 2; i++) begin
      eq = (bus.count_in == m_cmp[i]);
      if (eq && !m_prev_eq[i]) ev[i] = 1'b1;
      m_prev_eq[i] = eq;
    end
    if ((bus.m_in && m_prev_count == ONES && bus.count_in == '0) ||
        (!bus.m_in && m_prev_count == '0 && bus.count_in == ONES)) ev[3] = 1'b1;
`ifdef COUNT_EVENT_CAPTURE_EN
    // trig_hist[k] holds cap_trig as sampled k edges ago; the last sync stage lags by SYNC.
    trig_hist.push_front(bus.cap_trig);
    void'(trig_hist.pop_back());
    if (trig_hist[SYNC] && !trig_hist[SYNC+1]) begin
      if (m_cap_valid && !bus.cap_rd) m_cap_ovr = 1'b1;
      m_cap_value = bus.count_in;
      m_cap_valid = 1'b1;
      ev[2] = 1'b1;
    end else if (bus.cap_rd) begin
      m_cap_valid = 1'b0;
    end
`endif
    m_status = (m_status & ~bus.irq_ack) | ev;
    m_irq = |(m_status & m_mask);
    if (bus.cfg_wr) begin
      if (bus.cfg_sel == 2'd0) m_cmp[0] = bus.cfg_data;
      if (bus.cfg_sel == 2'd1) m_cmp[1] = bus.cfg_data;
      if (bus.cfg_sel == 2'd2) m_mask = bus.cfg_data[3:0];
    end
    m_prev_count = bus.count_in;
  endtask

  // Advance one clock; leaves the bench at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.cfg_wr = 1'b0; bus.cfg_sel = '0; bus.cfg_data = '0;
    bus.cap_rd = 1'b0; bus.irq_ack = '0;
  endtask

  task automatic write_cfg(input logic [1:0] sel, input logic [W-1:0] data);
    bus.cfg_wr = 1'b1; bus.cfg_sel = sel; bus.cfg_data = data;
    cycle();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.status, bus.irq, bus.cap_valid, bus.cap_ovr} !== 7'd0 || bus.cap_value !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got status=%b irq=%b valid=%b ovr=%b value=%h, want all 0",
               bus.status, bus.irq, bus.cap_valid, bus.cap_ovr, bus.cap_value);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (bus.status !== 4'd0 || bus.irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got status=%b irq=%b, want 0 0", bus.status, bus.irq);
    end
  endtask

  task automatic test_compare();
    write_cfg(2'd0, 32'd5);
    write_cfg(2'd2, 32'h1);
    for (int c = 0; c <= 8; c++) begin
      bus.count_in = c;
      for (int h = 0; h < ((c == 5) ? 3 : 1); h++) begin
        cycle();
        checks++;
        if (bus.status !== m_status || bus.irq !== m_irq) begin
          fails++;
          $display("FAIL compare_step count=%0d: got status=%b irq=%b, want status=%b irq=%b",
                   c, bus.status, bus.irq, m_status, m_irq);
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.status[0] !== 1'b1 || bus.irq !== 1'b1) begin
          fails++;
          $display("FAIL compare_hold: got status0=%b irq=%b, want 1 1", bus.status[0], bus.irq);
        end
      end
    end
    bus.irq_ack = 4'b0001;
    cycle();
    bus.irq_ack = 4'b0000;
    checks++;
    if (bus.status[0] !== 1'b0 || bus.irq !== 1'b0) begin
      fails++;
      $display("FAIL compare_ack: got status0=%b irq=%b, want 0 0", bus.status[0], bus.irq);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] a [3] = '{ONES, ONES, '0};
    logic [W-1:0] b [3] = '{'0, '0, ONES};
    logic         m [3] = '{1'b1, 1'b0, 1'b0};
    logic         want [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      bus.irq_ack = 4'b1000; bus.m_in = m[k]; bus.count_in = 32'h1234;
      cycle();
      bus.irq_ack = 4'b0000; bus.count_in = a[k];
      cycle();
      bus.count_in = b[k];
      cycle();
      checks++;
      if (bus.status[3] !== want[k] || bus.status !== m_status) begin
        fails++;
        $display("FAIL wrap_case%0d: got status=%b, want status3=%b model=%b",
                 k, bus.status, want[k], m_status);
      end
    end
    bus.m_in = 1'b1;
  endtask

  task automatic test_set_beats_clear();
    bus.count_in = 32'h40;
    write_cfg(2'd1, 32'h41);
    bus.irq_ack = 4'b1111;
    cycle();
    bus.count_in = 32'h41; bus.irq_ack = 4'b0010;
    cycle();
    bus.irq_ack = 4'b0000;
    checks++;
    if (bus.status[1] !== 1'b1 || bus.status !== m_status) begin
      fails++;
      $display("FAIL set_beats_clear: got status=%b, want status1=1 model=%b", bus.status, m_status);
    end
  endtask

  task automatic test_capture();
    bus.count_in = 32'h100;
    bus.cap_trig = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) bus.cap_trig = 1'b0;
      if (i == 6) bus.cap_trig = 1'b1;
      if (i == 7) bus.cap_trig = 1'b0;
      bus.count_in = bus.count_in + 1;
      cycle();
      checks++;
      if ({bus.cap_value, bus.cap_valid, bus.cap_ovr, bus.status} !==
          {m_cap_value, m_cap_valid, m_cap_ovr, m_status}) begin
        fails++;
        $display("FAIL capture_step%0d: got value=%h valid=%b ovr=%b status=%b, want %h %b %b %b",
                 i, bus.cap_value, bus.cap_valid, bus.cap_ovr, bus.status,
                 m_cap_value, m_cap_valid, m_cap_ovr, m_status);
      end
    end
    checks++;
`ifdef COUNT_EVENT_CAPTURE_EN
    // Second trigger sampled at the edge with count 0x107 is stored two edges later (0x109).
    if (bus.cap_ovr !== 1'b1 || bus.cap_valid !== 1'b1 || bus.cap_value !== 32'h109) begin
      fails++;
      $display("FAIL capture_overwrite: got ovr=%b valid=%b value=%h, want 1 1 00000109",
               bus.cap_ovr, bus.cap_valid, bus.cap_value);
    end
`else
    if (bus.cap_valid !== 1'b0 || bus.cap_value !== '0 || bus.status[2] !== 1'b0) begin
      fails++;
      $display("FAIL capture_disabled: got valid=%b value=%h status2=%b, want 0 0 0",
               bus.cap_valid, bus.cap_value, bus.status[2]);
    end
`endif
    bus.cap_rd = 1'b1;
    cycle();
    bus.cap_rd = 1'b0;
    checks++;
    if (bus.cap_valid !== 1'b0 || bus.cap_ovr !== m_cap_ovr) begin
      fails++;
      $display("FAIL capture_read: got valid=%b ovr=%b, want 0 %b", bus.cap_valid, bus.cap_ovr, m_cap_ovr);
    end
  endtask

  task automatic test_reset_mid();
    write_cfg(2'd2, 32'hF);
    bus.count_in = 32'h55; bus.cap_trig = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({bus.status, bus.irq, bus.cap_valid, bus.cap_ovr} !== 7'd0 || bus.cap_value !== '0) begin
      fails++;
      $display("FAIL reset_mid: got status=%b irq=%b valid=%b ovr=%b value=%h, want all 0",
               bus.status, bus.irq, bus.cap_valid, bus.cap_ovr, bus.cap_value);
    end
    bus.cap_trig = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.irq !== 1'b0 || bus.status !== m_status) begin
        fails++;
        $display("FAIL reset_release_irq: got irq=%b status=%b, want 0 %b", bus.irq, bus.status, m_status);
      end
    end
    write_cfg(2'd2, 32'h3);
    bus.m_in = 1'b1; bus.count_in = ONES;
    cycle();
    checks++;
    if (bus.status[1:0] !== 2'b11 || bus.irq !== 1'b1) begin
      fails++;
      $display("FAIL cmp_reset_value: got status=%b irq=%b, want status[1:0]=11 irq=1", bus.status, bus.irq);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] pick;
    for (int i = 0; i < 600; i++) begin
      idle_inputs();
      case ($urandom_range(0, 7))
        0: pick = m_cmp[0];
        1: pick = m_cmp[1];
        2: pick = '0;
        3: pick = ONES;
        4, 5: pick = m_prev_count + 1;
        6: pick = m_prev_count - 1;
        default: pick = $urandom_range(0, 15);
      endcase
      bus.count_in = pick;
      if ($urandom_range(0, 15) == 0) bus.m_in = ~bus.m_in;
      if ($urandom_range(0, 3) == 0) bus.cap_trig = ~bus.cap_trig;
      if ($urandom_range(0, 5) == 0) bus.cap_rd = 1'b1;
      if ($urandom_range(0, 3) == 0) bus.irq_ack = 4'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        bus.cfg_wr = 1'b1;
        bus.cfg_sel = 2'($urandom);
        bus.cfg_data = (bus.cfg_sel == 2'd2) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 15));
      end
      cycle();
      checks++;
      if ({bus.cap_value, bus.cap_valid, bus.cap_ovr, bus.status, bus.irq} !==
          {m_cap_value, m_cap_valid, m_cap_ovr, m_status, m_irq}) begin
        fails++;
        $display("FAIL random_cycle%0d: got value=%h valid=%b ovr=%b status=%b irq=%b, want %h %b %b %b %b",
                 i, bus.cap_value, bus.cap_valid, bus.cap_ovr, bus.status, bus.irq,
                 m_cap_value, m_cap_valid, m_cap_ovr, m_status, m_irq);
      end
    end
    idle_inputs();
  endtask

  initial begin
    bus.count_in = '0; bus.m_in = 1'b1; bus.cap_trig = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_compare();
    test_wrap();
    test_set_beats_clear();
    test_capture();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/count_event_unit.md
# count_event_unit

Downstream monitor for the 32-bit up/down counter. Consumes the counter's `count` and mode `m` each clock and raises sticky status events for:
- two programmable compare matches,
- counter wrap-around in either direction,
- an optional external capture of the count value.

Events feed a masked, level-type interrupt with a write-one-to-clear acknowledge.

## Interface
Parameters:
- `WIDTH`, 32, width of counter value, compare and capture registers.
- `SYNC_STAGES`, 2, synchronizer depth for `cap_trig` (legal: 2–3).

Ports:
- `clk` in 1 — clock; all state updates on rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `count_in` in WIDTH — counter value from the counter's `count` output.
- `m_in` in 1 — counter mode: 1 = up, 0 = down.
- `cfg_wr` in 1 — single-cycle write strobe for configuration.
- `cfg_sel` in 2 — target register: 0 = cmp0, 1 = cmp1, 2 = mask (bits [3:0]).
- `cfg_data` in WIDTH — write data.
- `cap_trig` in 1 — asynchronous external capture request; rising edge active.
- `cap_rd` in 1 — single-cycle strobe; consumer has read `cap_value`.
- `cap_value` out WIDTH — captured count.
- `cap_valid` out 1 — `cap_value` holds unread data.
- `cap_ovr` out 1 — sticky; a capture overwrote unread data.
- `status` out 4 — sticky events: [0] match0, [1] match1, [2] capture, [3] wrap.
- `irq_ack` in 4 — write-one-to-clear for `status` bits.
- `irq` out 1 — `|(status & mask)`, registered.

## Operation
Reset values: `cmp0` = `cmp1` = all-ones; mask = 0; `status` = 0; `cap_value` = 0; `cap_valid` = 0; `cap_ovr` = 0; `irq` = 0; `prev_count` = 0; `prev_eq0` = `prev_eq1` = 0; sync chain = 0.

Compare:
- `eqN` = (`count_in` == `cmpN`).
- A match event is the rising edge of `eqN` versus `prev_eqN`.
- A counter held at the compare value raises the event once only.
- Writing `cmpN` equal to the current `count_in` raises the event on the following cycle.

Wrap (sets `status[3]`):
- Up wrap: `m_in` = 1, `prev_count` = all-ones, `count_in` = 0.
- Down wrap: `m_in` = 0, `prev_count` = 0, `count_in` = all-ones.
- Counter reset from all-ones to 0 while `m_in` = 1 is indistinguishable and also counts as a wrap.
- `prev_count` registers `count_in` every cycle.

Capture:
- `cap_trig` passes through a SYNC_STAGES flop chain.
- A rising edge on the last stage loads `cap_value` ← `count_in`, sets `cap_valid` and `status[2]`.
- If `cap_valid` is already 1 when a capture occurs, `cap_ovr` sets and the value is overwritten.
- `cap_rd` clears `cap_valid`. If `cap_rd` and a capture occur in the same cycle, the capture wins: `cap_valid` stays 1 and `cap_ovr` is not set.
- `cap_ovr` clears only on reset.

Status and interrupt:
- Each `status` bit: next = (status & ~irq_ack) | event. Set beats clear in the same cycle.
- `irq` registered from next-state `status` & mask.
- Mask writes take effect on `irq` one cycle after the write.

Arithmetic: equality and wrap tests are exact WIDTH-bit compares. No arithmetic on `count_in`.

## Timing
- Compare/wrap: `count_in` condition true in the cycle ending at edge N → `status` bit high after edge N, `irq` high after edge N (same edge, from next-state).
- Capture: `cap_trig` high and stable before edge N → last sync stage high after edge N+SYNC_STAGES−1 → `cap_value`/`cap_valid` update at edge N+SYNC_STAGES. The value stored is `count_in` at that edge.
- `cap_trig` pulses shorter than one clock period may be missed; this is a documented limitation.
- Config write at edge N is visible to compare logic from cycle N+1.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). No event is raised on reset release.

## Configuration
- `COUNT_EVENT_CAPTURE_EN` defined: sync chain, capture register and `cap_ovr` logic are compiled in as described.
- Not defined: capture logic is removed. `cap_value` = 0, `cap_valid` = 0, `cap_ovr` = 0 constantly. `status[2]` is never set. `cap_trig` and `cap_rd` are ignored.

## Test plan
- Compare match: `cmp0` = 5, mask = 0001, counter up from 0 → `status[0]` and `irq` high after the edge where `count_in` = 5. They stay set while held; `irq_ack` = 0001 clears both the next cycle.
- Wrap up: drive `count_in` FFFFFFFF → 00000000 with `m_in` = 1 → `status[3]` = 1. Same sequence with `m_in` = 0 → no event. Down-wrap 0 → FFFFFFFF with `m_in` = 0 → `status[3]` = 1.
- Set beats clear: assert `irq_ack` = 0010 in the same cycle `count_in` first equals `cmp1` → `status[1]` remains 1.
- Capture (macro on): `count_in` = 0x100 ramping up, pulse `cap_trig` for 3 cycles → `cap_value` = `count_in` at edge N+2, `cap_valid` = 1. A second trigger before `cap_rd` → `cap_ovr` = 1 with the new value stored.
- Capture (macro off): same stimulus → `cap_valid`, `cap_value`, `status[2]` all stay 0.
- Reset mid-operation: assert `rst` with `status` = 1111 and `cap_valid` = 1 → all outputs 0 immediately. `cmp0`/`cmp1` read back all-ones; no spurious `irq` after release.
